// File: rtl/iquant_arith.sv
// rtl/iquant_arith.sv - MPEG-2 inverse-quantisation arithmetic with saturation and mismatch control
module iquant_arith (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_dta,
    input  logic [5:0]  in_addr,
    input  logic        in_eob,
    input  logic        in_intra,
    input  logic [6:0]  quantiser_scale,
    input  logic [1:0]  intra_dc_precision,
    output logic [5:0]  qm_rd_addr,
    output logic        qm_rd_clk_en,
    input  logic [7:0]  intra_qm_dta,
    input  logic [7:0]  non_intra_qm_dta,
    output logic        out_valid,
    output logic [5:0]  out_addr,
    output logic [11:0] out_dta,
    output logic        out_eob,
    output logic        out_sat
);

    typedef struct packed {
        logic [11:0] qf;
        logic [5:0]  addr;
        logic        eob;
        logic        intra;
        logic [6:0]  qs;
        logic [1:0]  prec;
    } beat_t;

    logic accept;
    logic eob_gap;

    assign accept       = in_valid && in_ready;
    // The cycle after an eob accept is left empty so a correction beat has a free output slot.
    assign in_ready     = !eob_gap;
    assign qm_rd_addr   = in_addr;
    assign qm_rd_clk_en = accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            eob_gap <= 1'b0;
        end else begin
            eob_gap <= accept && in_eob;
        end
    end

    // Stages 1 and 2 carry the beat while the matrix read completes.
    beat_t s1, s2;
    logic  s1_valid, s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s1       <= '{qf: in_dta, addr: in_addr, eob: in_eob, intra: in_intra,
                          qs: quantiser_scale, prec: intra_dc_precision};
            s2       <= s1;
        end
    end

    logic        [7:0]  w_sel;
    logic signed [13:0] k_term;
    logic signed [13:0] two_qf_k;
    logic signed [28:0] m_ext;
    logic signed [28:0] w_ext;
    logic signed [28:0] qs_ext;
    logic signed [28:0] qf_ext;
    logic signed [28:0] ac_prod;
    logic signed [28:0] dc_prod;
    logic               is_dc;

    always_comb begin
        w_sel    = s2.intra ? intra_qm_dta : non_intra_qm_dta;
        k_term   = 14'sd0;
        if (!s2.intra) begin
            if (s2.qf[11]) begin
                k_term = -14'sd1;
            end else if (s2.qf != 12'd0) begin
                k_term = 14'sd1;
            end
        end
        two_qf_k = $signed({s2.qf[11], s2.qf, 1'b0}) + k_term;
        m_ext    = 29'(two_qf_k);
        w_ext    = $signed({21'd0, w_sel});
        qs_ext   = $signed({22'd0, s2.qs});
        ac_prod  = m_ext * w_ext * qs_ext;
        qf_ext   = 29'($signed(s2.qf));
        case (s2.prec)
            2'd0:    dc_prod = qf_ext <<< 3;
            2'd1:    dc_prod = qf_ext <<< 2;
            2'd2:    dc_prod = qf_ext <<< 1;
            default: dc_prod = qf_ext;
        endcase
        is_dc    = s2.intra && (s2.addr == 6'd0);
    end

    logic               s3_valid;
    logic signed [28:0] s3_prod;
    logic               s3_dc;
    logic [5:0]         s3_addr;
    logic               s3_eob;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            s3_prod  <= is_dc ? dc_prod : ac_prod;
            s3_dc    <= is_dc;
            s3_addr  <= s2.addr;
            s3_eob   <= s2.eob;
        end
    end

    logic signed [28:0] adj;
    logic signed [28:0] quot;
    logic [11:0]        f_val;
    logic               f_sat;
    logic               parity;
    logic [11:0]        f63;
    logic               par_next;
    logic [11:0]        f63_next;

    // Truncation toward zero: bias negative products before the arithmetic shift.
    always_comb begin
        adj      = s3_prod + (s3_prod[28] ? 29'sd31 : 29'sd0);
        quot     = s3_dc ? s3_prod : (adj >>> 5);
        f_sat    = 1'b0;
        f_val    = quot[11:0];
        if (quot > 29'sd2047) begin
            f_val = 12'h7FF;
            f_sat = 1'b1;
        end else if (quot < -29'sd2048) begin
            f_val = 12'h800;
            f_sat = 1'b1;
        end
        par_next = parity ^ f_val[0];
        f63_next = (s3_addr == 6'd63) ? f_val : f63;
    end

    logic        fix_pending;
    logic [11:0] fix_dta;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_addr    <= 6'd0;
            out_dta     <= 12'd0;
            out_eob     <= 1'b0;
            out_sat     <= 1'b0;
            parity      <= 1'b0;
            f63         <= 12'd0;
            fix_pending <= 1'b0;
            fix_dta     <= 12'd0;
        end else begin
            out_valid   <= 1'b0;
            out_eob     <= 1'b0;
            out_sat     <= 1'b0;
            fix_pending <= 1'b0;
            if (s3_valid) begin
                out_valid <= 1'b1;
                out_addr  <= s3_addr;
                out_dta   <= f_val;
                out_sat   <= f_sat;
                out_eob   <= s3_eob && par_next;
                if (s3_eob) begin
                    parity      <= 1'b0;
                    f63         <= 12'd0;
                    fix_pending <= !par_next;
                    fix_dta     <= {f63_next[11:1], ~f63_next[0]};
                end else begin
                    parity <= par_next;
                    f63    <= f63_next;
                end
            end else if (fix_pending) begin
                out_valid <= 1'b1;
                out_addr  <= 6'd63;
                out_dta   <= fix_dta;
                out_eob   <= 1'b1;
            end
        end
    end

endmodule
